// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width function and default threshold constants.
package fifo_pkg;

    // Default almost-empty level and almost-full margin below depth, shared with the dual-clock FIFO.
    localparam int unsigned DEFAULT_AE_LEVEL  = 2;
    localparam int unsigned DEFAULT_AF_MARGIN = 2;

    // Number of address bits needed to index a FIFO of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             wr_en_i,
    input  logic [ptr_width(FIFO_DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    input  logic [ptr_width(FIFO_DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_c
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port: store on accepted push.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: combinational lookup of the addressed word.
    assign rd_data_c = mem[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost thresholds, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned ALMOST_FULL_LEVEL  = FIFO_DEPTH - DEFAULT_AF_MARGIN,
    parameter int unsigned ALMOST_EMPTY_LEVEL = DEFAULT_AE_LEVEL
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           write_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           read_enable,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic                           empty_flag,
    output logic                           full_flag,
    output logic                           almost_empty_flag,
    output logic                           almost_full_flag,
    output logic [ptr_width(FIFO_DEPTH):0] fill_count,
    output logic                           overflow_flag,
    output logic                           underflow_flag,
    input  logic                           error_clear
);

    localparam int unsigned AW = ptr_width(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (write_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_c (ram_rdata)
    );

    // Next-state for pointers, count, level flags and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        // Acceptance uses the registered full/empty, so full blocks a write even with a concurrent read.
        wr_accept = write_enable && !full_q  && !flush;
        rd_accept = read_enable  && !empty_q && !flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        aempty_d = (count_d <= AE_C);
        afull_d  = (count_d >= AF_C);

        // Clear first so a same-cycle error wins.
        if (error_clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (write_enable && full_q  && !flush) ovf_d = 1'b1;
        if (read_enable  && empty_q && !flush) udf_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign fill_count        = count_q;
    assign empty_flag        = empty_q;
    assign full_flag         = full_q;
    assign almost_empty_flag = aempty_q;
    assign almost_full_flag  = afull_q;
    assign overflow_flag     = ovf_q;
    assign underflow_flag    = udf_q;

`ifdef SYNC_FIFO_FWFT_EN
    // Head word presented directly; forced to zero while empty so the idle value is deterministic.
    assign read_data  = empty_q ? '0 : ram_rdata;
    assign read_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_accept;
        if (rd_accept) rdata_d = ram_rdata;
    end

    // Read output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
`endif

endmodule
